add_sub_flag_stage: RTL and testbench

//  Registered output stage directly downstream of the add/sub datapath. Takes
//  the raw sum and carry-out plus the operand sign bits and op select, derives
//  the Z/N/C/V condition flags, and presents result+flags on a valid/ready

---
 rtl/add_sub_pkg.sv | 31 +++
 rtl/add_sub_flag_stage_skid_buf.sv | 81 ++++++++
 rtl/add_sub_flag_stage.sv | 85 ++++++++
 tb/tb_add_sub_flag_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the add/sub flag output stage: flag bit positions,
// op-select encodings, skid buffer state type and the effective-B helper.
package add_sub_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

    localparam logic OPT_ADD = 1'b0;
    localparam logic OPT_SUB = 1'b1;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_MAIN  = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // Sign bit of the operand actually presented to the adder (B is inverted on SUB)
    function automatic logic eff_b_msb(input logic b_msb, input logic opt);
        logic res;
        case (opt)
            OPT_ADD: res = b_msb;
            OPT_SUB: res = ~b_msb;
            default: res = b_msb;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/add_sub_flag_stage_skid_buf.sv
// Two-entry skid buffer (main + skid register). Upstream ready is a register
// that only drops once both entries hold data, so it never depends
// combinationally on the downstream ready.
module skid_buf
    import add_sub_pkg::*;
#(
    parameter int DW = 36
) (
    input  logic          in_clk,
    input  logic          in_rst_n,
    input  logic          in_valid,
    output logic          out_ready_up,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          in_ready,
    output logic [DW-1:0] out_data
);

    buf_state_e    r_state;
    logic          r_ready;
    logic          r_valid;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;

    logic w_accept;
    logic w_deliver;

    assign w_accept  = in_valid & r_ready;
    assign w_deliver = r_valid & in_ready;

    // Buffer state machine: main register always feeds the output, skid catches the overflow beat
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= BUF_EMPTY;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (w_accept) begin
                        r_main  <= in_data;
                        r_valid <= 1'b1;
                        r_state <= BUF_MAIN;
                    end
                end
                BUF_MAIN: begin
                    if (w_accept && w_deliver) begin
                        r_main <= in_data;
                    end else if (w_accept) begin
                        r_skid  <= in_data;
                        r_ready <= 1'b0;
                        r_state <= BUF_FULL;
                    end else if (w_deliver) begin
                        r_valid <= 1'b0;
                        r_state <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    // Upstream is stalled here, so only a delivery can move the state
                    if (w_deliver) begin
                        r_main  <= r_skid;
                        r_ready <= 1'b1;
                        r_state <= BUF_MAIN;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= BUF_EMPTY;
                end
            endcase
        end
    end

    assign out_ready_up = r_ready;
    assign out_valid    = r_valid;
    assign out_data     = r_main;

endmodule

// File: rtl/add_sub_flag_stage.sv
// Registered output stage after the add/sub datapath: derives Z/N/C/V from
// the raw sum, carry and operand signs, and presents {flags,result} through a
// two-entry skid buffer.
// Optional feature macro: ADD_SUB_STICKY_OVF_EN (sticky overflow register).
module add_sub_flag_stage
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    input  logic               in_valid,
    output logic               out_ready_up,
    input  logic [WIDTH-1:0]   in_sum,
    input  logic               in_carry,
    input  logic               in_a_msb,
    input  logic               in_b_msb,
    input  logic               in_opt,
    output logic               out_valid,
    input  logic               in_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [FLAG_W-1:0]  out_flags,
    output logic               out_sticky_v,
    input  logic               in_clr_sticky
);

    logic [FLAG_W-1:0]       w_flags;
    logic                    w_bx;
    logic                    w_accept;
    logic [FLAG_W+WIDTH-1:0] w_in_data;
    logic [FLAG_W+WIDTH-1:0] w_out_data;

    assign w_bx = eff_b_msb(in_b_msb, in_opt);

    // Condition flags from the incoming beat; overflow when both effective operands share a sign the sum lacks
    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_Z] = (in_sum == '0);
        w_flags[FLAG_N] = in_sum[WIDTH-1];
        w_flags[FLAG_C] = in_carry;
        w_flags[FLAG_V] = (in_a_msb == w_bx) && (in_sum[WIDTH-1] != in_a_msb);
    end

    assign w_in_data = {w_flags, in_sum};
    assign w_accept  = in_valid & out_ready_up;

    skid_buf #(
        .DW (FLAG_W + WIDTH)
    ) u_skid_buf (
        .in_clk       (in_clk),
        .in_rst_n     (in_rst_n),
        .in_valid     (in_valid),
        .out_ready_up (out_ready_up),
        .in_data      (w_in_data),
        .out_valid    (out_valid),
        .in_ready     (in_ready),
        .out_data     (w_out_data)
    );

    assign out_result = w_out_data[WIDTH-1:0];
    assign out_flags  = w_out_data[WIDTH +: FLAG_W];

`ifdef ADD_SUB_STICKY_OVF_EN
    logic r_sticky_v;

    // Sticky overflow: an accepted overflowing beat sets it, and that set outranks a same-cycle clear
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_sticky_v <= 1'b0;
        end else if (w_accept && w_flags[FLAG_V]) begin
            r_sticky_v <= 1'b1;
        end else if (in_clr_sticky) begin
            r_sticky_v <= 1'b0;
        end
    end

    assign out_sticky_v = r_sticky_v;
`else
    logic w_unused_clr;

    assign w_unused_clr = in_clr_sticky;
    assign out_sticky_v = 1'b0;
`endif

endmodule

// File: tb/tb_add_sub_flag_stage.sv
// Testbench for add_sub_flag_stage: directed flag vectors from a table,
// hand-written skid/reset/sticky sequences, then randomized traffic checked
// against an occupancy/queue model with flags computed by signed arithmetic.
module tb_add_sub_flag_stage;

    localparam int     W    = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          out_ready_up;
    logic [W-1:0]  in_sum;
    logic          in_carry;
    logic          in_a_msb;
    logic          in_b_msb;
    logic          in_opt;
    logic          out_valid;
    logic          in_ready;
    logic [W-1:0]  out_result;
    logic [3:0]    out_flags;
    logic          out_sticky_v;
    logic          in_clr_sticky;

    add_sub_flag_stage #(.WIDTH(W)) dut (
        .in_clk        (clk),
        .in_rst_n      (rst_n),
        .in_valid      (in_valid),
        .out_ready_up  (out_ready_up),
        .in_sum        (in_sum),
        .in_carry      (in_carry),
        .in_a_msb      (in_a_msb),
        .in_b_msb      (in_b_msb),
        .in_opt        (in_opt),
        .out_valid     (out_valid),
        .in_ready      (in_ready),
        .out_result    (out_result),
        .out_flags     (out_flags),
        .out_sticky_v  (out_sticky_v),
        .in_clr_sticky (in_clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: ordered list of beats inside the stage, each {V,C,N,Z,result}
    logic [35:0]  exp_q[$];
    logic         m_sticky = 1'b0;
    logic [31:0]  out_log[$];
    int           n_delivered = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what an ideal adder produces plus flags from plain integer arithmetic
    function automatic logic [35:0] ref_beat(input logic [31:0] a, input logic [31:0] b, input logic op);
        longint sa, sb, sr;
        logic [31:0] s;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op) begin
            s  = a - b;
            c  = (a >= b);
            sr = sa - sb;
        end else begin
            s  = a + b;
            c  = (longint'(a) + longint'(b)) > 64'sd4294967295;
            sr = sa + sb;
        end
        v = (sr > MAXS) || (sr < MINS);
        return {v, c, s[31], (s == 32'd0), s};
    endfunction

    // Compare outputs with the model, then drive one cycle and advance the model at the edge
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic rdy, input logic clr, output logic acc);
        logic [35:0] r;
        logic del;
        chk("out_valid", out_valid, exp_q.size() > 0);
        chk("ready_up", out_ready_up, exp_q.size() < 2);
        chk("sticky_v", out_sticky_v, m_sticky);
        if (exp_q.size() > 0) begin
            chk("result", out_result, exp_q[0][31:0]);
            chk("flags", out_flags, exp_q[0][35:32]);
        end
        r = ref_beat(a, b, op);
        in_valid      = v;
        in_sum        = r[31:0];
        in_carry      = r[34];
        in_a_msb      = a[31];
        in_b_msb      = b[31];
        in_opt        = op;
        in_ready      = rdy;
        in_clr_sticky = clr;
        acc = v && (exp_q.size() < 2);
        del = (exp_q.size() > 0) && rdy;
        if (del) begin
            $display("out beat %0d: result=%h flags=%b", n_delivered, out_result, out_flags);
            out_log.push_back(out_result);
            n_delivered++;
        end
        @(posedge clk);
        if (del) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(r);
`ifdef ADD_SUB_STICKY_OVF_EN
        if (acc && r[35]) m_sticky = 1'b1;
        else if (clr) m_sticky = 1'b0;
`endif
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, acc);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [3:0]  flg;   // {V,C,N,Z}
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic acc;
        logic [31:0] r1, r2, r3;
        int tries;

        tbl[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1010};
        tbl[1] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 4'b0101};
        tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0101};
        tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b1100};
        tbl[4] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 4'b0010};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b1101};

        rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_carry = 1'b0; in_a_msb = 1'b0;
        in_b_msb = 1'b0; in_opt = 1'b0; in_ready = 1'b0; in_clr_sticky = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", out_ready_up, 1);
        chk("rst_result", out_result, 0);
        chk("rst_flags", out_flags, 0);
        chk("rst_sticky", out_sticky_v, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed flag vectors
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, 1'b1, 1'b0, acc);
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_result", i), out_result, tbl[i].res);
            chk($sformatf("vec%0d_flags", i), out_flags, tbl[i].flg);
            drain();
        end

        // Skid fill: downstream stalled, three back-to-back beats
        r1 = 32'h11; r2 = 32'h22; r3 = 32'h33;
        out_log.delete();
        cycle(1'b1, r1, 0, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, r2, 0, 1'b0, 1'b0, 1'b0, acc);
        chk("ready_fall_after_2nd", out_ready_up, 0);
        cycle(1'b1, r3, 0, 1'b0, 1'b0, 1'b0, acc);
        chk("beat3_held_ready", out_ready_up, 0);
        chk("beat3_not_taken", exp_q.size(), 2);
        tries = 0;
        do begin
            cycle(1'b1, r3, 0, 1'b0, 1'b1, 1'b0, acc);
            tries++;
        end while (!acc && tries < 10);
        chk("beat3_accepted", acc, 1);
        drain();
        chk("order_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("order_1", out_log[0], r1);
            chk("order_2", out_log[1], r2);
            chk("order_3", out_log[2], r3);
        end

        // Streaming: 16 beats, downstream always ready
        n_delivered = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, $urandom, $urandom, 1'($urandom), 1'b1, 1'b0, acc);
            chk("stream_accept", acc, 1);
            chk("stream_latency_valid", out_valid, 1);
        end
        drain();
        chk("stream_delivered", n_delivered, 16);

`ifdef ADD_SUB_STICKY_OVF_EN
        cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, acc);
        chk("sticky_cleared", out_sticky_v, 0);
        cycle(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, acc);
        chk("sticky_set", out_sticky_v, 1);
        cycle(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1, acc);
        chk("sticky_set_wins", out_sticky_v, 1);
        cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, acc);
        chk("sticky_clear", out_sticky_v, 0);
        drain();
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0), acc);
        end
        drain();

        // Async reset with a full buffer
        cycle(1'b1, 32'hAAAA_0001, 0, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'hAAAA_0002, 0, 1'b0, 1'b0, 1'b0, acc);
        chk("full_before_reset", out_ready_up, 0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_valid_now", out_valid, 0);
        chk("reset_ready_now", out_ready_up, 1);
        chk("reset_result_now", out_result, 0);
        chk("reset_sticky_now", out_sticky_v, 0);
        exp_q.delete();
        m_sticky = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cycle(1'b1, 32'h5, 32'h3, 1'b1, 1'b1, 1'b0, acc);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
